alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Controller that time-shares one ALU_DESIGN instance between N requesters.
- Round-robin arbitration over valid/ready request channels, then sequences the ALU through issue, a command-dependent latency wait, and result capture.
- Returns each result, tagged with the requester ID, on a single valid/ready response channel.
- Sits between the operand sources and the ALU in the top-level datapath.

Parameters:
- N, 4: number of requesters (2..8).
- WIDTH, 8: ALU operand width.
- ALU_LAT, 1: cycles from issue until ALU outputs are sampled, non-multiply commands (>=1).
- MUL_LAT, 2: same, for multiply commands (>=1).

Ports:
- CLK  in  1  clock; all logic is rising-edge.
- RST  in  1  synchronous active-high reset.
- req_valid  in  N  request pending, one bit per requester.
- req_ready  out  N  one-hot grant/accept pulse.
- req_opa, req_opb  in  N*WIDTH  packed operands, requester i at [i*WIDTH +: WIDTH].
- req_cmd  in  N*4  packed commands.
- req_mode  in  N  per-requester MODE (1 = arithmetic).
- req_cin  in  N  per-requester carry in.
- req_inp_valid  in  N*2  packed INP_VALID.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  $clog2(N)  requester ID of the response.
- rsp_res  out  2*WIDTH  captured RES.
- rsp_flags  out  6  {ERR,OFLOW,COUT,G,L,E}, captured.
- busy  out  1  high in any state except IDLE.
- alu_opa, alu_opb  out  WIDTH  to ALU OPA/OPB.
- alu_cmd  out  4  to ALU CMD.
- alu_mode  out  1  to ALU MODE.
- alu_cin  out  1  to ALU CIN.
- alu_inp_valid  out  2  to ALU INP_VALID.
- alu_ce  out  1  to ALU CE.
- alu_res  in  2*WIDTH  from ALU RES.
- alu_g, alu_l, alu_e, alu_err, alu_cout, alu_oflow  in  1 each  from ALU.

Behaviour:
- Reset (RST=1 at a rising edge):
  - State goes to IDLE; RR pointer = 0.
  - All outputs 0: req_ready, rsp_*, busy, alu_*.
  - Any in-flight operation is abandoned; no response is produced.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, arbitration:
  - Combinationally pick the first requester with req_valid set, searching upward from the RR pointer with wrap (N-1 wraps to 0).
  - If one is found: assert req_ready[g] for that cycle only. At the edge, capture its opa/opb/cmd/mode/cin/inp_valid into holding registers, store g, set pointer = (g+1) mod N, go to ISSUE.
  - No req_valid: stay in IDLE, req_ready = 0.
- ISSUE (1 cycle):
  - alu_* driven from the holding registers; alu_ce = 1.
  - Load wait counter with lat - 1, where lat = MUL_LAT if mode=1 and cmd is 9 or 10, else ALU_LAT. Go to WAIT.
- WAIT (exactly lat cycles):
  - alu_* held stable, alu_ce = 1.
  - Counter decrements each cycle. In the cycle where the counter is 0, the edge captures alu_res and flags into rsp_res/rsp_flags, sets rsp_id = g and rsp_valid = 1, and moves to RESP.
- RESP:
  - alu_ce = 0; alu operand outputs hold their last values.
  - rsp_valid held with data stable until rsp_ready = 1 at an edge; then rsp_valid = 0 and go to IDLE.
  - rsp_ready while rsp_valid = 0 is ignored.
- Throughput: one operation per (lat + 3) cycles with rsp_ready tied high. No overlap of requests.
- The controller does not validate cmd or inp_valid. ALU error flags pass through in rsp_flags unchanged.
- A requester must hold its request fields stable while req_valid=1 and until its req_ready pulse. Dropping req_valid before grant is legal; the requester is simply skipped.
- Simultaneous requests: exactly one grant per arbitration; a continuously requesting agent waits at most N-1 grants.
- busy = (state != IDLE).

Test Plan:
- Reset mid-WAIT with requester 2 issuing an add → next cycle all outputs 0, no rsp_valid ever appears for that op, pointer = 0.
- Single request: requester 1, mode=1, cmd=0 (ADD), opa=8'h0F, opb=8'h01, cin=0, inp_valid=2'b11 → req_ready[1] pulses in cycle 0. rsp_valid rises at cycle 1 + ALU_LAT + 1 (cycle 3 with ALU_LAT=1), rsp_id=1, rsp_res=16'h0010, E/G/L per ALU.
- All four req_valid held high, rsp_ready=1 → grant order 0,1,2,3,0; each grant spaced ALU_LAT+3 = 4 cycles.
- Multiply: requester 3, mode=1, cmd=9, opa=3, opb=4 → WAIT lasts MUL_LAT=2 cycles, alu_ce high for 3 cycles total, rsp_res matches the ALU result.
- Backpressure: rsp_ready low for 5 cycles → rsp_valid and data stable, no new req_ready while waiting. Next grant occurs in the cycle after the rsp_ready handshake.
- Invalid op, requester 0, inp_valid=2'b00 → completes normally with rsp_flags ERR bit = alu_err (1).

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Time-shares one ALU between N requesters: round-robin grant, issue, latency wait,
// then a tagged valid/ready response.
module alu_share_ctrl #(
  parameter int N       = 4,
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  input  logic [N*WIDTH-1:0]     req_opa,
  input  logic [N*WIDTH-1:0]     req_opb,
  input  logic [N*4-1:0]         req_cmd,
  input  logic [N-1:0]           req_mode,
  input  logic [N-1:0]           req_cin,
  input  logic [N*2-1:0]         req_inp_valid,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [$clog2(N)-1:0]   rsp_id,
  output logic [2*WIDTH-1:0]     rsp_res,
  output logic [5:0]             rsp_flags,
  output logic                   busy,
  output logic [WIDTH-1:0]       alu_opa,
  output logic [WIDTH-1:0]       alu_opb,
  output logic [3:0]             alu_cmd,
  output logic                   alu_mode,
  output logic                   alu_cin,
  output logic [1:0]             alu_inp_valid,
  output logic                   alu_ce,
  input  logic [2*WIDTH-1:0]     alu_res,
  input  logic                   alu_g,
  input  logic                   alu_l,
  input  logic                   alu_e,
  input  logic                   alu_err,
  input  logic                   alu_cout,
  input  logic                   alu_oflow
);

  localparam int ID_W    = $clog2(N);
  localparam int MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   hold_id;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  hold_opa, hold_opb;
  logic [3:0]        hold_cmd;
  logic              hold_mode, hold_cin;
  logic [1:0]        hold_iv;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   idx;
  logic              is_mul;
  logic [CNT_W-1:0]  lat_m1;

  // Round-robin search starting at the pointer, wrapping past N-1
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = ID_W'((int'(ptr) + k) % N);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  assign is_mul = hold_mode && (hold_cmd == 4'd9 || hold_cmd == 4'd10);
  assign lat_m1 = is_mul ? CNT_W'(MUL_LAT - 1) : CNT_W'(ALU_LAT - 1);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_id] = 1'b1;
          state_nxt         = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT:  if (cnt == '0) state_nxt = RESP;
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_id   <= '0;
      cnt       <= '0;
      hold_opa  <= '0;
      hold_opb  <= '0;
      hold_cmd  <= '0;
      hold_mode <= 1'b0;
      hold_cin  <= 1'b0;
      hold_iv   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_res   <= '0;
      rsp_flags <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            hold_opa  <= req_opa[gnt_id*WIDTH +: WIDTH];
            hold_opb  <= req_opb[gnt_id*WIDTH +: WIDTH];
            hold_cmd  <= req_cmd[gnt_id*4 +: 4];
            hold_mode <= req_mode[gnt_id];
            hold_cin  <= req_cin[gnt_id];
            hold_iv   <= req_inp_valid[gnt_id*2 +: 2];
            hold_id   <= gnt_id;
            ptr       <= (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
          end
        end
        ISSUE: cnt <= lat_m1;
        WAIT: begin
          if (cnt == '0) begin
            rsp_res   <= alu_res;
            rsp_flags <= {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};
            rsp_id    <= hold_id;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Holding registers feed the ALU directly, so operands stay put after the op completes
  assign alu_opa       = hold_opa;
  assign alu_opb       = hold_opb;
  assign alu_cmd       = hold_cmd;
  assign alu_mode      = hold_mode;
  assign alu_cin       = hold_cin;
  assign alu_inp_valid = hold_iv;
  assign alu_ce        = (state == ISSUE) || (state == WAIT);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a small pipelined ALU stand-in.
module tb_alu_share_ctrl;
  localparam int N = 4;
  localparam int W = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic [N-1:0]     req_valid, req_ready, req_mode, req_cin;
  logic [N*W-1:0]   req_opa, req_opb;
  logic [N*4-1:0]   req_cmd;
  logic [N*2-1:0]   req_inp_valid;
  logic             rsp_valid, rsp_ready, busy;
  logic [1:0]       rsp_id;
  logic [2*W-1:0]   rsp_res;
  logic [5:0]       rsp_flags;
  logic [W-1:0]     alu_opa, alu_opb;
  logic [3:0]       alu_cmd;
  logic             alu_mode, alu_cin, alu_ce;
  logic [1:0]       alu_inp_valid;
  logic [2*W-1:0]   alu_res;
  logic             alu_g, alu_l, alu_e, alu_err, alu_cout, alu_oflow;

  alu_share_ctrl #(.N(N), .WIDTH(W), .ALU_LAT(1), .MUL_LAT(2)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
    .req_mode(req_mode), .req_cin(req_cin), .req_inp_valid(req_inp_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags), .busy(busy),
    .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
    .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_inp_valid(alu_inp_valid),
    .alu_ce(alu_ce), .alu_res(alu_res),
    .alu_g(alu_g), .alu_l(alu_l), .alu_e(alu_e),
    .alu_err(alu_err), .alu_cout(alu_cout), .alu_oflow(alu_oflow)
  );

  always #5 CLK = ~CLK;

  // ALU stand-in: one register stage per enabled cycle; multiply reads the second stage
  function automatic logic [21:0] alu_f(logic [7:0] a, logic [7:0] b, logic [3:0] c,
                                        logic m, logic [1:0] iv);
    logic [15:0] r;
    logic [8:0]  s;
    logic        er, co;
    r = '0; er = 1'b0; co = 1'b0;
    s = {1'b0, a} + {1'b0, b};
    if (iv != 2'b11) er = 1'b1;
    else if (m) begin
      case (c)
        4'd0: begin r = {7'b0, s}; co = s[8]; end
        4'd9: r = {8'b0, a} * {8'b0, b};
        default: r = '0;
      endcase
    end
    return {er, 1'b0, co, (a > b), (a < b), (a == b), r};
  endfunction

  logic [21:0] s1 = '0, s2 = '0;
  logic        mul_sel;
  always @(posedge CLK) if (alu_ce) begin
    s1 <= alu_f(alu_opa, alu_opb, alu_cmd, alu_mode, alu_inp_valid);
    s2 <= s1;
  end
  assign mul_sel = alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10);
  assign {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_res} = mul_sel ? s2 : s1;

  typedef struct { logic [1:0] id; logic [15:0] res; logic [5:0] flags; } exp_t;
  typedef struct { logic [3:0] rdy; int cyc; } gnt_t;
  exp_t sb[$];
  gnt_t gq[$];
  int   rise_q[$];
  int   errors = 0, checks = 0, cyc = 0, ce_cnt = 0;
  logic rv_prev = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(logic [1:0] id, logic [15:0] res, logic [5:0] flags);
    exp_t e;
    e.id = id; e.res = res; e.flags = flags;
    sb.push_back(e);
  endtask

  always @(posedge CLK) cyc++;

  // Monitors: grants, response rise times, ALU enable cycles, and scoreboard pops
  always @(negedge CLK) begin
    if (req_ready != '0) gq.push_back('{req_ready, cyc});
    if (rsp_valid && !rv_prev) rise_q.push_back(cyc);
    rv_prev = rsp_valid;
    if (alu_ce) ce_cnt++;
    if (!RST && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got id %0d res %0h, none expected", rsp_id, rsp_res);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_res", 32'(rsp_res), 32'(e.res));
        check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
      end
    end
  end

  task automatic set_req(int i, logic [7:0] a, logic [7:0] b, logic [3:0] c,
                         logic m, logic [1:0] iv);
    req_opa[i*W +: W]       = a;
    req_opb[i*W +: W]       = b;
    req_cmd[i*4 +: 4]       = c;
    req_mode[i]             = m;
    req_cin[i]              = 1'b0;
    req_inp_valid[i*2 +: 2] = iv;
    req_valid[i]            = 1'b1;
  endtask

  task automatic wait_grants(int n, string name);
    int k = 0;
    while (gq.size() < n && k < 60) begin @(posedge CLK); k++; end
    #1;
    check(name, 32'(gq.size() >= n), 32'd1);
  endtask

  task automatic wait_drain(string name);
    int k = 0;
    while (sb.size() > 0 && k < 60) begin @(posedge CLK); k++; end
    #1;
    check(name, 32'(sb.size()), 32'd0);
  endtask

  function automatic int first_lat(int gcyc);
    if (rise_q.size() == 0) return -1;
    return rise_q.pop_front() - gcyc;
  endfunction

  initial begin
    gnt_t g;
    int   gc[5];
    int   hits;
    logic [3:0] order_exp [5];
    order_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    RST = 1'b1; req_valid = '0; req_opa = '0; req_opb = '0; req_cmd = '0;
    req_mode = '0; req_cin = '0; req_inp_valid = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_ce", 32'(alu_ce), 32'd0);
    check("rst_rsp_res", 32'(rsp_res), 32'd0);

    // Reset mid-WAIT abandons the op
    gq.delete();
    set_req(2, 8'h11, 8'h22, 4'd0, 1'b1, 2'b11);
    wait_grants(1, "midwait_grant_seen");
    g = gq.pop_front();
    check("midwait_grant", 32'(g.rdy), 32'h4);
    req_valid = '0;
    @(posedge CLK); #1;
    check("midwait_in_wait_ce", 32'(alu_ce), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    check("midwait_busy", 32'(busy), 32'd0);
    check("midwait_alu_ce", 32'(alu_ce), 32'd0);
    check("midwait_alu_opa", 32'(alu_opa), 32'd0);
    check("midwait_rsp_valid", 32'(rsp_valid), 32'd0);
    hits = 0;
    repeat (4) begin @(negedge CLK); if (rsp_valid) hits++; end
    check("midwait_no_rsp", 32'(hits), 32'd0);

    // All four requesting: pointer restarts at 0, order 0,1,2,3,0 spaced 4 cycles
    @(posedge CLK); #1;
    gq.delete(); rise_q.delete();
    expect_rsp(2'd0, 16'h0040, 6'b000001);
    expect_rsp(2'd1, 16'h0041, 6'b000100);
    expect_rsp(2'd2, 16'h0042, 6'b000100);
    expect_rsp(2'd3, 16'h0043, 6'b000100);
    expect_rsp(2'd0, 16'h0040, 6'b000001);
    for (int i = 0; i < N; i++) set_req(i, 8'h20 + 8'(i), 8'h20, 4'd0, 1'b1, 2'b11);
    wait_grants(5, "rr_grants_seen");
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      if (gq.size() > 0) begin g = gq.pop_front(); gc[i] = g.cyc; end
      else begin g.rdy = '0; gc[i] = 0; end
      check("rr_order", 32'(g.rdy), 32'(order_exp[i]));
      if (i > 0) check("rr_spacing", 32'(gc[i] - gc[i-1]), 32'd4);
    end
    wait_drain("rr_drain");

    // Single add from requester 1: response three cycles after grant
    gq.delete(); rise_q.delete();
    expect_rsp(2'd1, 16'h0010, 6'b000100);
    set_req(1, 8'h0F, 8'h01, 4'd0, 1'b1, 2'b11);
    wait_grants(1, "single_grant_seen");
    g = gq.pop_front();
    check("single_grant", 32'(g.rdy), 32'h2);
    req_valid = '0;
    wait_drain("single_drain");
    check("single_latency", 32'(first_lat(g.cyc)), 32'd3);

    // Multiply from requester 3: two-cycle WAIT, enable high three cycles
    gq.delete(); rise_q.delete(); ce_cnt = 0;
    expect_rsp(2'd3, 16'h000C, 6'b000010);
    set_req(3, 8'd3, 8'd4, 4'd9, 1'b1, 2'b11);
    wait_grants(1, "mul_grant_seen");
    g = gq.pop_front();
    check("mul_grant", 32'(g.rdy), 32'h8);
    req_valid = '0;
    wait_drain("mul_drain");
    check("mul_latency", 32'(first_lat(g.cyc)), 32'd4);
    check("mul_ce_cycles", 32'(ce_cnt), 32'd3);

    // Backpressure: response held five cycles, requester 2 waits for the handshake
    gq.delete(); rise_q.delete();
    rsp_ready = 1'b0;
    expect_rsp(2'd0, 16'h000C, 6'b000010);
    expect_rsp(2'd2, 16'h0002, 6'b000001);
    set_req(0, 8'd5, 8'd7, 4'd0, 1'b1, 2'b11);
    set_req(2, 8'd1, 8'd1, 4'd0, 1'b1, 2'b11);
    wait_grants(1, "bp_grant_seen");
    g = gq.pop_front();
    check("bp_grant", 32'(g.rdy), 32'h1);
    req_valid[0] = 1'b0;
    hits = 0;
    while (!rsp_valid && hits < 20) begin @(negedge CLK); hits++; end
    check("bp_rsp_valid_rise", 32'(rsp_valid), 32'd1);
    repeat (5) begin
      @(negedge CLK);
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_id", 32'(rsp_id), 32'd0);
      check("bp_hold_res", 32'(rsp_res), 32'h000C);
      check("bp_hold_flags", 32'(rsp_flags), 32'b000010);
      check("bp_no_grant", 32'(req_ready), 32'd0);
    end
    @(posedge CLK); #1 rsp_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("bp_next_grant", 32'(req_ready), 32'h4);
    @(posedge CLK); #1 req_valid = '0;
    wait_drain("bp_drain");

    // Missing operands: op completes with the ALU error flag passed through
    gq.delete();
    expect_rsp(2'd0, 16'h0000, 6'b100001);
    set_req(0, 8'd0, 8'd0, 4'd0, 1'b1, 2'b00);
    wait_grants(1, "err_grant_seen");
    g = gq.pop_front();
    check("err_grant", 32'(g.rdy), 32'h1);
    req_valid = '0;
    wait_drain("err_drain");

    repeat (3) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: sim time exceeded, expected completion");
    $fatal(1);
  end
endmodule
